// File: rtl/vga_timing_gen.sv
// Pixel-clock timing source for the video pipeline: hcount/vcount, active-high syncs,
// blanking, line/frame markers and a frame counter. Every flag describes the count it ships with.
module vga_timing_gen #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [10:0] hcount,
  output logic [10:0] vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        hblnk,
  output logic        vblnk,
  output logic [11:0] rgb,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_cfg
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 2048");
    end
  endgenerate

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  // Window bounds kept at 12 bits so an edge landing exactly on 2048 still compares correctly
  localparam logic [11:0] HB_BEG = 12'(H_ACTIVE);
  localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VB_BEG = 12'(V_ACTIVE);
  localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);

  logic        h_wrap, f_wrap;
  logic [10:0] h_nxt, v_nxt;
  logic [11:0] h_ext, v_ext;

  always_comb begin
    h_wrap = (hcount == H_LAST);
    f_wrap = h_wrap && (vcount == V_LAST);
    h_nxt  = h_wrap ? 11'd0 : hcount + 11'd1;
    v_nxt  = vcount;
    if (f_wrap)      v_nxt = 11'd0;
    else if (h_wrap) v_nxt = vcount + 11'd1;
    h_ext  = {1'b0, h_nxt};
    v_ext  = {1'b0, v_nxt};
  end

  // Flags are derived from the next counts so they register alongside them with no skew
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount      <= '0;
      vcount      <= '0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else if (en) begin
      hcount      <= h_nxt;
      vcount      <= v_nxt;
      hblnk       <= (h_ext >= HB_BEG);
      vblnk       <= (v_ext >= VB_BEG);
      hsync       <= (h_ext >= HS_BEG) && (h_ext < HS_END);
      vsync       <= (v_ext >= VS_BEG) && (v_ext < VS_END);
      line_start  <= h_wrap;
      frame_start <= f_wrap;
      if (f_wrap) frame_cnt <= frame_cnt + 16'd1;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

  assign rgb = 12'h000;

endmodule
